// File: rtl/id_pkg.sv
// id_pkg: shared definitions for the instruction-decode stage.
// Holds the opcode width, opcode class constants, the control-bit bundle,
// the per-cycle stage action encoding and the opcode decode function.
package id_pkg;

  // Opcode occupies the top OPCODE_W bits of every instruction.
  localparam int OPCODE_W = 5;

  // The all-zero opcode is a NOP regardless of its class bits.
  localparam logic [OPCODE_W-1:0] OP_NOP = 5'b00000;

  // Opcode class, taken from opcode[4:3].
  localparam logic [1:0] CLS_ALU_R = 2'b00;
  localparam logic [1:0] CLS_ALU_I = 2'b01;
  localparam logic [1:0] CLS_LOAD  = 2'b10;
  localparam logic [1:0] CLS_STORE = 2'b11;

  // Control bits carried alongside an instruction into execute.
  typedef struct packed {
    logic regwrite;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
  } ctrl_t;

  // What the stage does on the coming clock edge, highest priority first:
  // flush, execute stall, load-use hazard, normal advance.
  typedef enum logic [1:0] {
    ACT_NORMAL = 2'b00,
    ACT_HAZARD = 2'b01,
    ACT_STALL  = 2'b10,
    ACT_FLUSH  = 2'b11
  } act_e;

  // Map an opcode to its control bits; NOP yields all zeros.
  function automatic ctrl_t decode(input logic [OPCODE_W-1:0] opcode);
    ctrl_t c;
    c = '0;
    if (opcode != OP_NOP) begin
      case (opcode[OPCODE_W-1 -: 2])
        CLS_ALU_R: begin
          c.regwrite = 1'b1;
        end
        CLS_ALU_I: begin
          c.regwrite = 1'b1;
          c.alu_src  = 1'b1;
        end
        CLS_LOAD: begin
          c.regwrite   = 1'b1;
          c.mem_read   = 1'b1;
          c.mem_to_reg = 1'b1;
          c.alu_src    = 1'b1;
        end
        default: begin
          c.mem_write = 1'b1;
          c.alu_src   = 1'b1;
        end
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// id_regfile: architectural register file, 2**REG_AW entries of DATA_W bits.
// Two combinational read ports, one synchronous write port, async reset
// clears every entry (r0 is an ordinary writable register).
// Optional feature macro: ID_BYPASS_EN -- when defined, a read whose address
// matches an active write returns the write data in the same cycle.
module id_regfile #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [REG_AW-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b
);

  localparam int NREGS = 2 ** REG_AW;

  logic [DATA_W-1:0] r_regs [NREGS];

  // Storage: cleared on reset, written at the clock edge when enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

`ifdef ID_BYPASS_EN
  logic w_hit_a;
  logic w_hit_b;

  // Write-through: a same-cycle write to the addressed register wins.
  always_comb begin
    w_hit_a   = i_we && (i_waddr == i_raddr_a);
    w_hit_b   = i_we && (i_waddr == i_raddr_b);
    o_rdata_a = w_hit_a ? i_wdata : r_regs[i_raddr_a];
    o_rdata_b = w_hit_b ? i_wdata : r_regs[i_raddr_b];
  end
`else
  // Plain reads: a same-cycle write is only visible from the next cycle.
  always_comb begin
    o_rdata_a = r_regs[i_raddr_a];
    o_rdata_b = r_regs[i_raddr_b];
  end
`endif

endmodule

// File: rtl/id_stage.sv
// id_stage: instruction-decode stage between fetch and execute.
// Owns the IF/ID register, the register file (id_regfile), the control
// decoder, load-use hazard detection and the ID/EX register, plus a
// saturating count of hazard stall cycles.
// Optional feature macro: ID_BYPASS_EN (register-file write-through),
// implemented inside id_regfile.
//
// Handshake: an instruction moves from fetch into IF/ID on a rising edge
// where in_valid && in_ready; in_ready never depends on in_valid. During a
// flush in_ready is 1 but the accepted instruction is discarded. out_valid
// marks ID/EX as holding a real instruction; execute holds it by raising
// ex_stall, and the registered outputs stay stable for as long as it does.
module id_stage
  import id_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int REG_AW  = 3,
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instruction_input,
  input  logic               wb_regwrite,
  input  logic [REG_AW-1:0]  wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  input  logic               ex_stall,
  input  logic               flush,
  output logic               out_valid,
  output logic               regwrite_out,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               alu_src,
  output logic [DATA_W-1:0]  rd_data,
  output logic [DATA_W-1:0]  rs_data,
  output logic [INSTR_W-1:0] instruction_output,
  output logic [CNT_W-1:0]   stall_cnt
);

  // Field positions: opcode on top, then rd, then rs, immediate below.
  localparam int RD_LSB = INSTR_W - OPCODE_W - REG_AW;
  localparam int RS_LSB = RD_LSB - REG_AW;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Goes high one edge after reset releases; gates acceptance.
  logic               r_rst_done;

  // IF/ID register.
  logic               r_ifid_valid;
  logic [INSTR_W-1:0] r_ifid_instr;

  // ID/EX register.
  logic               r_idex_valid;
  ctrl_t              r_idex_ctrl;
  logic [DATA_W-1:0]  r_idex_rd_data;
  logic [DATA_W-1:0]  r_idex_rs_data;
  logic [INSTR_W-1:0] r_idex_instr;

  logic [CNT_W-1:0]   r_stall_cnt;

  logic [OPCODE_W-1:0] w_ifid_opcode;
  logic [REG_AW-1:0]   w_ifid_rd;
  logic [REG_AW-1:0]   w_ifid_rs;
  logic [REG_AW-1:0]   w_idex_rd;
  ctrl_t               w_ifid_ctrl;
  logic [DATA_W-1:0]   w_rd_val;
  logic [DATA_W-1:0]   w_rs_val;
  logic                w_hazard;
  logic                w_take;
  act_e                w_act;

  assign w_ifid_opcode = r_ifid_instr[INSTR_W-1 -: OPCODE_W];
  assign w_ifid_rd     = r_ifid_instr[RD_LSB +: REG_AW];
  assign w_ifid_rs     = r_ifid_instr[RS_LSB +: REG_AW];
  assign w_idex_rd     = r_idex_instr[RD_LSB +: REG_AW];
  assign w_ifid_ctrl   = decode(w_ifid_opcode);

  id_regfile #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .i_we      (wb_regwrite),
    .i_waddr   (wb_addr),
    .i_wdata   (wb_data),
    .i_raddr_a (w_ifid_rd),
    .o_rdata_a (w_rd_val),
    .i_raddr_b (w_ifid_rs),
    .o_rdata_b (w_rs_val)
  );

  // Load-use hazard: a load in ID/EX writes a register the IF/ID
  // instruction names. A bubble in ID/EX has mem_read=0, so it self-clears.
  always_comb begin
    w_hazard = r_idex_valid && r_idex_ctrl.mem_read &&
               r_ifid_valid && (w_ifid_opcode != OP_NOP) &&
               ((w_idex_rd == w_ifid_rd) || (w_idex_rd == w_ifid_rs));
  end

  // Pick this cycle's action by priority and derive in_ready from it.
  always_comb begin
    w_act = ACT_NORMAL;
    if (flush) begin
      w_act = ACT_FLUSH;
    end else if (ex_stall) begin
      w_act = ACT_STALL;
    end else if (w_hazard) begin
      w_act = ACT_HAZARD;
    end
    in_ready = r_rst_done && ((w_act == ACT_NORMAL) || (w_act == ACT_FLUSH));
    w_take   = in_valid && r_rst_done;
  end

  // Post-reset enable for in_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
    end
  end

  // IF/ID: load from fetch on normal, empty on flush, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ifid_valid <= 1'b0;
      r_ifid_instr <= '0;
    end else begin
      case (w_act)
        ACT_FLUSH: begin
          r_ifid_valid <= 1'b0;
          r_ifid_instr <= '0;
        end
        ACT_NORMAL: begin
          r_ifid_valid <= w_take;
          r_ifid_instr <= w_take ? instruction_input : '0;
        end
        default: begin
          r_ifid_valid <= r_ifid_valid;
          r_ifid_instr <= r_ifid_instr;
        end
      endcase
    end
  end

  // ID/EX: decoded IF/ID on normal, bubble on flush/hazard, hold on stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idex_valid   <= 1'b0;
      r_idex_ctrl    <= '0;
      r_idex_rd_data <= '0;
      r_idex_rs_data <= '0;
      r_idex_instr   <= '0;
    end else begin
      case (w_act)
        ACT_NORMAL: begin
          if (r_ifid_valid) begin
            r_idex_valid   <= 1'b1;
            r_idex_ctrl    <= w_ifid_ctrl;
            r_idex_rd_data <= w_rd_val;
            r_idex_rs_data <= w_rs_val;
            r_idex_instr   <= r_ifid_instr;
          end else begin
            r_idex_valid   <= 1'b0;
            r_idex_ctrl    <= '0;
            r_idex_rd_data <= '0;
            r_idex_rs_data <= '0;
            r_idex_instr   <= '0;
          end
        end
        ACT_STALL: begin
          r_idex_valid   <= r_idex_valid;
          r_idex_ctrl    <= r_idex_ctrl;
          r_idex_rd_data <= r_idex_rd_data;
          r_idex_rs_data <= r_idex_rs_data;
          r_idex_instr   <= r_idex_instr;
        end
        default: begin
          r_idex_valid   <= 1'b0;
          r_idex_ctrl    <= '0;
          r_idex_rd_data <= '0;
          r_idex_rs_data <= '0;
          r_idex_instr   <= '0;
        end
      endcase
    end
  end

  // Count hazard bubbles, sticking at all-ones; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if ((w_act == ACT_HAZARD) && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end
  end

  assign out_valid          = r_idex_valid;
  assign regwrite_out       = r_idex_ctrl.regwrite;
  assign mem_read           = r_idex_ctrl.mem_read;
  assign mem_write          = r_idex_ctrl.mem_write;
  assign mem_to_reg         = r_idex_ctrl.mem_to_reg;
  assign alu_src            = r_idex_ctrl.alu_src;
  assign rd_data            = r_idex_rd_data;
  assign rs_data            = r_idex_rs_data;
  assign instruction_output = r_idex_instr;
  assign stall_cnt          = r_stall_cnt;

endmodule

// File: doc/id_stage.md
# id_stage

Parametrised instruction-decode stage for the RISC core, sitting between fetch and execute. It owns the IF/ID register, the architectural register file, the control decoder and the ID/EX register. Over a fixed 8-bit/8-register decoder it adds:
- generic data width and register count
- valid/ready flow control with downstream stall and flush
- load-use hazard detection with bubble insertion
- a saturating stall counter

## Interface
Parameters:
- DATA_W, 8, register/data width in bits
- REG_AW, 3, register address width; register count = 2**REG_AW
- INSTR_W, 16, instruction width; must be ≥ 5 + 2*REG_AW
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset; asynchronous, active-high; clears all state including the register file
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- instruction_input  in  INSTR_W  fetched instruction
- wb_regwrite  in  1  writeback enable
- wb_addr  in  REG_AW  writeback register
- wb_data  in  DATA_W  writeback value
- ex_stall  in  1  execute cannot accept; hold the stage
- flush  in  1  discard the instructions in IF/ID and ID/EX
- out_valid  out  1  ID/EX holds a real instruction
- regwrite_out, mem_read, mem_write, mem_to_reg, alu_src  out  1 each  registered control bits
- rd_data, rs_data  out  DATA_W  registered operands
- instruction_output  out  INSTR_W  registered instruction
- stall_cnt  out  CNT_W  hazard-stall cycles, saturating

## Operation
- Fields:
  - opcode = instr[INSTR_W-1 -: 5]
  - rd = next REG_AW bits below the opcode
  - rs = next REG_AW bits below rd
  - the remainder is the immediate, passed through untouched
- Decode, keyed on opcode[4:3]; opcode 5'b00000 is NOP with all control bits 0:
  - 00 ALU-reg: regwrite
  - 01 ALU-imm: regwrite, alu_src
  - 10 LOAD: regwrite, mem_read, mem_to_reg, alu_src
  - 11 STORE: mem_write, alu_src
- Register file: 2 combinational read ports (rd, rs) and 1 synchronous write port. Every register, including r0, is writable.
- Load-use hazard (`hazard`): asserted when ID/EX is valid with mem_read=1, IF/ID is valid and non-NOP, and the ID/EX rd equals the IF/ID rd or rs.
- Priority per cycle: flush > ex_stall > hazard > normal.
  - flush: IF/ID.valid←0 and ID/EX.valid←0 at the edge. in_ready=1, but the accepted instruction is discarded.
  - ex_stall: IF/ID and ID/EX hold. in_ready=0.
  - hazard: IF/ID holds. ID/EX loads a bubble. in_ready=0. stall_cnt increments.
  - normal: ID/EX←decode(IF/ID). IF/ID←instruction_input with valid=in_valid. in_ready=1.
- Bubble: out_valid=0; all control bits, operands and instruction_output are 0.
- stall_cnt saturates at all-ones and is cleared only by rst.

## Timing
- Reset values: IF/ID and ID/EX invalid; every output 0 except in_ready, which is 1 one cycle after rst deasserts (0 during rst); stall_cnt 0; all registers 0.
- Latency: an instruction accepted at edge N appears on the outputs after edge N+1, i.e. 2 cycles, absent stalls.
- Hazard costs exactly 1 bubble cycle. Once the load moves on, the comparison re-evaluates against the bubble (mem_read=0), so the stall releases.
- rst mid-operation: all state clears immediately; in-flight instructions are lost.
- Write and read to the same address in the same cycle: see Configuration.

## Configuration
- ID_BYPASS_EN defined: a read port whose address equals wb_addr while wb_regwrite=1 returns wb_data in the same cycle (write-through).
- ID_BYPASS_EN undefined: the read returns the old register value, and software must separate a writeback and a dependent decode by 1 cycle.

## Structure
- Package id_pkg holds:
  - opcode class constants (OP_NOP, CLS_ALU_R, CLS_ALU_I, CLS_LOAD, CLS_STORE)
  - the opcode width (5)
  - the ctrl_t struct of the 5 control bits and the decode function
- One sub-module, id_regfile, parametrised by DATA_W/REG_AW; it contains the ID_BYPASS_EN logic.
- Pipeline registers, hazard logic and the counter stay in id_stage.

## Test plan
- Reset then ALU-reg {00001, rd=2, rs=3}, with r2=0x11 and r3=0x22 preloaded via wb → 2 cycles later out_valid=1, regwrite_out=1, rd_data=0x11, rs_data=0x22.
- LOAD rd=4 followed by ALU-reg rs=4 → one bubble (out_valid=0), in_ready=0 for 1 cycle, stall_cnt=1, then the ALU instruction issues.
- ex_stall held 3 cycles mid-stream → outputs frozen, in_ready=0, no instruction lost or duplicated.
- flush together with ex_stall and a pending hazard → next cycle out_valid=0, IF/ID empty, stall_cnt unchanged.
- wb write r5=0xA5 in the same cycle that decode reads r5 → rs_data=0xA5 with ID_BYPASS_EN, old value 0x00 without.
- Force 2**CNT_W+3 hazards (CNT_W=4 build) → stall_cnt sticks at 0xF; rst asserted mid-stream → all outputs 0 asynchronously.
